bitonic_merge_node: RTL and testbench



---
 rtl/bitonic_merge_node.sv | 102 ++++++++++
 tb/tb_bitonic_merge_node.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/bitonic_merge_node.sv
// bitonic_merge_node: merges two ascending 8-key word streams through a 16-key bitonic network with feedback
module bitonic_merge_node #(
  parameter int DATA_WIDTH = 256
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_fifo_1,
  input  logic                  i_fifo_1_empty,
  output logic                  o_fifo_1_read,
  input  logic [DATA_WIDTH-1:0] i_fifo_2,
  input  logic                  i_fifo_2_empty,
  output logic                  o_fifo_2_read,
  input  logic                  i_fifo_out_ready,
  output logic                  o_out_fifo_write,
  output logic [DATA_WIDTH-1:0] o_data
);
  typedef enum logic [1:0] {MERGE, FLUSH, TERM} state_t;
  state_t state;
  logic [2:0] enq, deq, empty, full;
  logic [2:0][DATA_WIDTH-1:0] din, head;
  logic [DATA_WIDTH-1:0] t, w, lo, hi;
  logic tv, ta, tb, sel_b, both, step;
  logic [31:0] s [5][16];

  assign o_fifo_1_read = ~i_fifo_1_empty & ~full[0];
  assign o_fifo_2_read = ~i_fifo_2_empty & ~full[1];
  assign o_out_fifo_write = i_fifo_out_ready & ~empty[2];
  assign o_data = empty[2] ? '0 : head[2];
  assign enq[0] = o_fifo_1_read;
  assign enq[1] = o_fifo_2_read;
  assign deq[2] = o_out_fifo_write;
  assign din[0] = i_fifo_1;
  assign din[1] = i_fifo_2;

  // fifo 0/1 buffer the input streams, fifo 2 the merged output
  for (genvar f = 0; f < 3; f++) begin : g_fifo
    logic [DATA_WIDTH-1:0] mem [16];
    logic [3:0] wp, rp;
    logic [4:0] cnt;
    logic do_enq, do_deq;
    assign empty[f] = cnt == 5'd0;
    assign full[f] = cnt == 5'd16;
    assign head[f] = mem[rp];
    assign do_deq = deq[f] & ~empty[f];
    assign do_enq = enq[f] & (~full[f] | do_deq);
    always_ff @(posedge i_clk) begin
      if (do_enq) mem[wp] <= din[f];
      if (i_rst) begin
        wp <= '0;
        rp <= '0;
        cnt <= '0;
      end else begin
        wp <= wp + 4'(do_enq);
        rp <= rp + 4'(do_deq);
        cnt <= cnt + 5'(do_enq) - 5'(do_deq);
      end
    end
  end

  assign ta = head[0][31:0] == 32'd0;
  assign tb = head[1][31:0] == 32'd0;
  assign both = ta & tb;
  assign sel_b = ta | (~tb & (head[1][31:0] < head[0][31:0]));
  assign w = sel_b ? head[1] : head[0];
  assign step = (state == MERGE) & ~empty[0] & ~empty[1] & ~full[2];
  assign deq[0] = step & (both | ~sel_b);
  assign deq[1] = step & (both | sel_b);
  assign enq[2] = ~full[2] & ((state == MERGE) ? step & ~both & tv : (state == FLUSH) ? tv : (state == TERM));
  assign din[2] = (state == FLUSH) ? t : (state == TERM) ? '0 : lo;

  // T ascending followed by W reversed forms a bitonic sequence
  always_comb begin
    lo = '0;
    hi = '0;
    for (int i = 0; i < 8; i++) begin
      s[0][i] = t[32*i +: 32];
      s[0][8+i] = w[32*(7-i) +: 32];
    end
    for (int l = 0; l < 4; l++)
      for (int i = 0; i < 16; i++)
        s[l+1][i] = ((s[l][i] < s[l][i ^ (8 >> l)]) == ((i & (8 >> l)) == 0)) ? s[l][i] : s[l][i ^ (8 >> l)];
    for (int i = 0; i < 8; i++) begin
      lo[32*i +: 32] = s[4][i];
      hi[32*i +: 32] = s[4][8+i];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= MERGE;
      t <= '0;
      tv <= 1'b0;
    end else if (step & both) state <= FLUSH;
    else if (step) begin
      t <= tv ? hi : w;
      tv <= 1'b1;
    end else if (state == FLUSH & ~full[2]) begin
      tv <= 1'b0;
      state <= TERM;
    end else if (state == TERM & ~full[2]) state <= MERGE;
  end
endmodule

// File: tb/tb_bitonic_merge_node.sv
// tb_bitonic_merge_node: scoreboard bench; expected output is a full sort of all streamed keys
module tb_bitonic_merge_node;
  typedef logic [255:0] word_t;
  logic i_clk = 0, i_rst = 1;
  word_t i_fifo_1, i_fifo_2, o_data;
  logic i_fifo_1_empty, i_fifo_2_empty, o_fifo_1_read, o_fifo_2_read;
  logic i_fifo_out_ready, o_out_fifo_write;
  word_t qa[$], qb[$], exp_q[$];
  logic hold_a = 0, hold_b = 0, tie_mode = 0;
  int n_chk = 0, n_pass = 0, n_out = 0;

  bitonic_merge_node dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_fifo_1(i_fifo_1),
    .i_fifo_1_empty(i_fifo_1_empty),
    .o_fifo_1_read(o_fifo_1_read),
    .i_fifo_2(i_fifo_2),
    .i_fifo_2_empty(i_fifo_2_empty),
    .o_fifo_2_read(o_fifo_2_read),
    .i_fifo_out_ready(i_fifo_out_ready),
    .o_out_fifo_write(o_out_fifo_write),
    .o_data(o_data)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input word_t got, input word_t want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s got=%h want=%h", tag, got, want);
  endtask

  function automatic word_t mk(input int base, input int st);
    word_t r;
    for (int k = 0; k < 8; k++) r[32*k +: 32] = 32'(base + st * k);
    return r;
  endfunction

  task automatic drive();
    i_fifo_1 = qa.size() != 0 ? qa[0] : '0;
    i_fifo_2 = qb.size() != 0 ? qb[0] : '0;
    i_fifo_1_empty = hold_a | qa.size() == 0;
    i_fifo_2_empty = hold_b | qb.size() == 0;
  endtask

  task automatic load(input word_t a[$], input word_t b[$]);
    logic [31:0] keys[$];
    foreach (a[i]) if (a[i][31:0] != 0) for (int k = 0; k < 8; k++) keys.push_back(a[i][32*k +: 32]);
    foreach (b[i]) if (b[i][31:0] != 0) for (int k = 0; k < 8; k++) keys.push_back(b[i][32*k +: 32]);
    keys.sort();
    for (int i = 0; i < keys.size(); i += 8) begin
      word_t r;
      for (int k = 0; k < 8; k++) r[32*k +: 32] = keys[i+k];
      exp_q.push_back(r);
    end
    exp_q.push_back('0);
    foreach (a[i]) qa.push_back(a[i]);
    foreach (b[i]) qb.push_back(b[i]);
    drive();
  endtask

  task automatic rand_stream(output word_t q[$], input int n);
    logic [31:0] keys[$];
    word_t r;
    for (int i = 0; i < 8 * n; i++) keys.push_back(32'($urandom_range(1, 100000)));
    keys.sort();
    q = {};
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 8; k++) r[32*k +: 32] = keys[8*i+k];
      q.push_back(r);
    end
    q.push_back('0);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge i_clk);
    #2;
  endtask

  task automatic drain(input string tag);
    int c = 0;
    while ((exp_q.size() != 0 || qa.size() != 0 || qb.size() != 0) && c < 1000) begin
      tick(1);
      c++;
    end
    check(tag, word_t'(exp_q.size()), 0);
    tick(5);
  endtask

  initial begin
    logic ra, rb;
    forever begin
      @(negedge i_clk);
      ra = o_fifo_1_read;
      rb = o_fifo_2_read;
      @(posedge i_clk);
      #1;
      if (ra) void'(qa.pop_front());
      if (rb) void'(qb.pop_front());
      drive();
    end
  end

  initial forever begin
    @(negedge i_clk);
    if (tie_mode && dut.deq[1:0] != 2'b00) begin
      check("tie_order", word_t'(dut.deq[1:0]), 1);
      tie_mode = 0;
    end
    if (o_out_fifo_write && !i_rst) begin
      n_out++;
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL extra_word got=%h want=none", o_data);
      end else check("out", o_data, exp_q.pop_front());
    end
  end

  initial begin
    word_t a[$], b[$];
    word_t z;
    int n0, c;
    z = '0;
    i_fifo_out_ready = 1;
    drive();
    tick(3);
    check("rst_write", word_t'(o_out_fifo_write), 0);
    check("rst_data", o_data, 0);
    i_rst = 0;
    tick(1);
    a = {mk(1, 2), mk(17, 2), z};
    b = {mk(2, 2), mk(18, 2), z};
    load(a, b);
    drain("interleave");
    tie_mode = 1;
    load({mk(5, 0), z}, {mk(5, 0), z});
    drain("tie");
    check("tie_seen", word_t'(tie_mode), 0);
    load({mk(1, 1), mk(9, 1), z}, {z});
    drain("single_side");
    load({z}, {z});
    drain("empty_pair");
    hold_b = 1;
    load(a, b);
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (i % 5 == 4) check("stall_nowrite", word_t'(o_out_fifo_write), 0);
    end
    check("stall_a_held", word_t'(dut.g_fifo[0].cnt), 3);
    hold_b = 0;
    drive();
    drain("stall_resume");
    i_fifo_out_ready = 0;
    load(a, b);
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (i % 10 == 9) check("bp_nowrite", word_t'(o_out_fifo_write), 0);
    end
    check("bp_cnt", word_t'(dut.g_fifo[2].cnt), 5);
    i_fifo_out_ready = 1;
    drain("bp_release");
    i_fifo_out_ready = 0;
    rand_stream(a, 14);
    rand_stream(b, 14);
    load(a, b);
    for (int i = 0; i < 60; i++) tick(1);
    check("bp_nowrite_full", word_t'(o_out_fifo_write), 0);
    check("bp_full", word_t'(dut.g_fifo[2].cnt), 16);
    i_fifo_out_ready = 1;
    drain("bp_random");
    a = {mk(1, 2), mk(17, 2), z};
    b = {mk(2, 2), mk(18, 2), z};
    load(a, b);
    n0 = n_out;
    c = 0;
    while (n_out < n0 + 2 && c < 200) begin
      tick(1);
      c++;
    end
    check("pre_rst_words", word_t'(n_out - n0), 2);
    i_rst = 1;
    qa.delete();
    qb.delete();
    exp_q.delete();
    drive();
    tick(1);
    i_rst = 0;
    check("mid_rst_data", o_data, 0);
    check("mid_rst_write", word_t'(o_out_fifo_write), 0);
    check("mid_rst_tv", word_t'(dut.tv), 0);
    check("mid_rst_cnt_a", word_t'(dut.g_fifo[0].cnt), 0);
    check("mid_rst_cnt_b", word_t'(dut.g_fifo[1].cnt), 0);
    check("mid_rst_cnt_o", word_t'(dut.g_fifo[2].cnt), 0);
    load(a, b);
    drain("post_rst");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
